// File: rtl/legv8_pkg.sv
// Shared constants for the LEGv8 ALU issue sequencer: FS encodings, opcodes, condition
// codes, status bit positions, FSM states and the latched per-op record.
package legv8_pkg;

   localparam int unsigned IW  = 32;
   localparam int unsigned FSW = 5;
   localparam int unsigned SW  = 4;

   // ALU function select: [0] Ainv, [1] Binv, [4:2] operation
   localparam logic [FSW-1:0] FS_AND = 5'b00000;
   localparam logic [FSW-1:0] FS_OR  = 5'b00100;
   localparam logic [FSW-1:0] FS_ADD = 5'b01000;
   localparam logic [FSW-1:0] FS_SUB = 5'b01010;
   localparam logic [FSW-1:0] FS_XOR = 5'b01100;
   localparam logic [FSW-1:0] FS_LSL = 5'b10000;
   localparam logic [FSW-1:0] FS_LSR = 5'b10100;

   // R-type opcodes, instr[31:21]
   localparam logic [10:0] OP_ADD  = 11'b10001011000;
   localparam logic [10:0] OP_ADDS = 11'b10101011000;
   localparam logic [10:0] OP_SUB  = 11'b11001011000;
   localparam logic [10:0] OP_SUBS = 11'b11101011000;
   localparam logic [10:0] OP_AND  = 11'b10001010000;
   localparam logic [10:0] OP_ANDS = 11'b11101010000;
   localparam logic [10:0] OP_ORR  = 11'b10101010000;
   localparam logic [10:0] OP_EOR  = 11'b11001010000;
   localparam logic [10:0] OP_LSL  = 11'b11010011011;
   localparam logic [10:0] OP_LSR  = 11'b11010011010;

   // I-type opcodes, instr[31:22]
   localparam logic [9:0] OP_ADDI  = 10'b1001000100;
   localparam logic [9:0] OP_ADDIS = 10'b1011000100;
   localparam logic [9:0] OP_SUBI  = 10'b1101000100;
   localparam logic [9:0] OP_SUBIS = 10'b1111000100;
   localparam logic [9:0] OP_ANDI  = 10'b1001001000;
   localparam logic [9:0] OP_ORRI  = 10'b1011001000;
   localparam logic [9:0] OP_EORI  = 10'b1101001000;

   // B.cond, instr[31:24]
   localparam logic [7:0] OP_BCOND = 8'b01010100;

   // Condition pairs by cond[3:1]; cond[0] inverts (except AL)
   localparam logic [2:0] CB_EQ = 3'b000;
   localparam logic [2:0] CB_HS = 3'b001;
   localparam logic [2:0] CB_MI = 3'b010;
   localparam logic [2:0] CB_VS = 3'b011;
   localparam logic [2:0] CB_HI = 3'b100;
   localparam logic [2:0] CB_GE = 3'b101;
   localparam logic [2:0] CB_GT = 3'b110;
   localparam logic [2:0] CB_AL = 3'b111;

   // Status vector layout {V,C,N,Z}
   localparam int unsigned SB_Z = 0;
   localparam int unsigned SB_N = 1;
   localparam int unsigned SB_C = 2;
   localparam int unsigned SB_V = 3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   typedef struct packed {
      logic       setflags;
      logic       is_bcond;
      logic       illegal;
      logic       wr_en;
      logic [4:0] rd;
      logic [3:0] cond;
   } op_info_t;

   function automatic logic cond_pass(input logic [3:0] cond, input logic [SW-1:0] st);
      logic ge;
      logic r;
      ge = (st[SB_N] == st[SB_V]);
      unique case (cond[3:1])
         CB_EQ:   r = st[SB_Z];
         CB_HS:   r = st[SB_C];
         CB_MI:   r = st[SB_N];
         CB_VS:   r = st[SB_V];
         CB_HI:   r = st[SB_C] & ~st[SB_Z];
         CB_GE:   r = ge;
         CB_GT:   r = ~st[SB_Z] & ge;
         default: r = 1'b1;
      endcase
      return (cond[0] && (cond[3:1] != CB_AL)) ? ~r : r;
   endfunction

endpackage

// File: rtl/legv8_alu_decode.sv
// Combinational opcode decode: instr[31:21] -> ALU function select, carry-in,
// B-operand source and op classification.
module legv8_alu_decode
   import legv8_pkg::*;
(
   input  logic [10:0]    opcode,
   output logic [FSW-1:0] fs,
   output logic           c0,
   output logic           bsel_imm12,
   output logic           bsel_shamt,
   output logic           setflags,
   output logic           is_bcond,
   output logic           illegal
);

   always_comb begin
      fs         = FS_AND;
      c0         = 1'b0;
      bsel_imm12 = 1'b0;
      bsel_shamt = 1'b0;
      setflags   = 1'b0;
      is_bcond   = 1'b0;
      illegal    = 1'b0;
      case (opcode)
         OP_ADD:  fs = FS_ADD;
         OP_ADDS: begin fs = FS_ADD; setflags = 1'b1; end
         OP_SUB:  begin fs = FS_SUB; c0 = 1'b1; end
         OP_SUBS: begin fs = FS_SUB; c0 = 1'b1; setflags = 1'b1; end
         OP_AND:  fs = FS_AND;
         OP_ANDS: begin fs = FS_AND; setflags = 1'b1; end
         OP_ORR:  fs = FS_OR;
         OP_EOR:  fs = FS_XOR;
         OP_LSL:  begin fs = FS_LSL; bsel_shamt = 1'b1; end
         OP_LSR:  begin fs = FS_LSR; bsel_shamt = 1'b1; end
         default: begin
            // Not R-type: try the 10-bit immediate forms, then B.cond
            bsel_imm12 = 1'b1;
            case (opcode[10:1])
               OP_ADDI:  fs = FS_ADD;
               OP_ADDIS: begin fs = FS_ADD; setflags = 1'b1; end
               OP_SUBI:  begin fs = FS_SUB; c0 = 1'b1; end
               OP_SUBIS: begin fs = FS_SUB; c0 = 1'b1; setflags = 1'b1; end
               OP_ANDI:  fs = FS_AND;
               OP_ORRI:  fs = FS_OR;
               OP_EORI:  fs = FS_XOR;
               default: begin
                  bsel_imm12 = 1'b0;
                  if (opcode[10:3] == OP_BCOND) is_bcond = 1'b1;
                  else                          illegal  = 1'b1;
               end
            endcase
         end
      endcase
   end

endmodule

// File: rtl/legv8_alu_sequencer.sv
// Issue side of the LEGv8 ALU: accepts one op, drives the ALU for one cycle, captures
// F/status, keeps the NZCV register and resolves B.cond. One op per three cycles.
module legv8_alu_sequencer
   import legv8_pkg::*;
#(
   parameter int unsigned DW = 64
) (
   input  logic           clock,
   input  logic           reset_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [IW-1:0]  in_instr,
   input  logic [DW-1:0]  in_a,
   input  logic [DW-1:0]  in_b,
   output logic [DW-1:0]  alu_a,
   output logic [DW-1:0]  alu_b,
   output logic [FSW-1:0] alu_fs,
   output logic           alu_c0,
   input  logic [DW-1:0]  alu_f,
   input  logic [SW-1:0]  alu_status,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [DW-1:0]  out_result,
   output logic [4:0]     out_rd,
   output logic           out_wr_en,
   output logic           out_br_taken,
   output logic           out_illegal,
   output logic [SW-1:0]  flags
);

   state_t   state_q, state_d;
   op_info_t op_q;

   logic [FSW-1:0] dec_fs;
   logic           dec_c0, dec_imm12, dec_shamt, dec_setflags, dec_bcond, dec_illegal;
   logic           accept;
   logic           no_alu;
   logic           unused_rn;

   legv8_alu_decode u_decode (
      .opcode     (in_instr[31:21]),
      .fs         (dec_fs),
      .c0         (dec_c0),
      .bsel_imm12 (dec_imm12),
      .bsel_shamt (dec_shamt),
      .setflags   (dec_setflags),
      .is_bcond   (dec_bcond),
      .illegal    (dec_illegal)
   );

   // Rn index is consumed upstream by the register read; only its value arrives here
   assign unused_rn = ^in_instr[9:5];

   assign accept = (state_q == ST_IDLE) && in_valid && in_ready;
   assign no_alu = dec_bcond || dec_illegal;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (accept) state_d = ST_EXEC;
         ST_EXEC: state_d = ST_RESP;
         ST_RESP: if (out_ready) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // in_ready mirrors "next state is IDLE", so it reads 0 for the first cycle out of reset
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         in_ready     <= 1'b0;
         alu_a        <= '0;
         alu_b        <= '0;
         alu_fs       <= '0;
         alu_c0       <= 1'b0;
         op_q         <= '0;
         out_valid    <= 1'b0;
         out_result   <= '0;
         out_rd       <= '0;
         out_wr_en    <= 1'b0;
         out_br_taken <= 1'b0;
         out_illegal  <= 1'b0;
         flags        <= '0;
      end else begin
         in_ready <= (state_d == ST_IDLE);

         if (accept) begin
            alu_a  <= no_alu ? '0 : in_a;
            alu_b  <= no_alu    ? '0 :
                      dec_imm12 ? DW'(in_instr[21:10]) :
                      dec_shamt ? DW'(in_instr[15:10]) : in_b;
            alu_fs <= dec_fs;
            alu_c0 <= dec_c0;
            op_q.setflags <= dec_setflags;
            op_q.is_bcond <= dec_bcond;
            op_q.illegal  <= dec_illegal;
            op_q.wr_en    <= !no_alu && (in_instr[4:0] != 5'd31);
            op_q.rd       <= in_instr[4:0];
            op_q.cond     <= in_instr[3:0];
         end

         if (state_q == ST_EXEC) begin
            out_valid    <= 1'b1;
            out_result   <= (op_q.is_bcond || op_q.illegal) ? '0 : alu_f;
            out_rd       <= op_q.rd;
            out_wr_en    <= op_q.wr_en;
            out_br_taken <= op_q.is_bcond && cond_pass(op_q.cond, flags);
            out_illegal  <= op_q.illegal;
            if (op_q.setflags) flags <= alu_status;
         end else if (state_q == ST_RESP && out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_legv8_alu_sequencer.sv
// Bench for legv8_alu_sequencer: behavioural ALU, instruction-level reference model,
// directed scenarios with literal expectations, then randomized ops.
module tb_legv8_alu_sequencer;

   typedef struct packed {
      logic [63:0] res;
      logic [4:0]  rd;
      logic        wr;
      logic        br;
      logic        ill;
      logic [3:0]  fl;
   } exp_t;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_instr = '0;
   logic [63:0] in_a = '0, in_b = '0;
   logic [63:0] alu_a, alu_b, alu_f;
   logic [4:0]  alu_fs;
   logic        alu_c0;
   logic [3:0]  alu_status;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [63:0] out_result;
   logic [4:0]  out_rd;
   logic        out_wr_en, out_br_taken, out_illegal;
   logic [3:0]  flags;

   int   tests = 0;
   int   fails = 0;
   bit   mon_en = 0;
   exp_t exp_q[$];
   exp_t mon_e;
   logic [3:0]  mflags = '0;
   logic [63:0] last_result;
   logic [3:0]  last_flags;
   logic        last_wr, last_br, last_ill;

   always #5 clock = ~clock;

   legv8_alu_sequencer dut (
      .clock(clock), .reset_n(reset_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
      .in_a(in_a), .in_b(in_b),
      .alu_a(alu_a), .alu_b(alu_b), .alu_fs(alu_fs), .alu_c0(alu_c0),
      .alu_f(alu_f), .alu_status(alu_status),
      .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
      .out_rd(out_rd), .out_wr_en(out_wr_en), .out_br_taken(out_br_taken),
      .out_illegal(out_illegal), .flags(flags)
   );

   // Stand-in for the 64-bit ALU; C and V come from the adder only
   logic [63:0] ta, tbb;
   logic [64:0] tsum;
   logic        ac, av;
   always_comb begin
      ta    = alu_fs[0] ? ~alu_a : alu_a;
      tbb   = alu_fs[1] ? ~alu_b : alu_b;
      tsum  = {1'b0, ta} + {1'b0, tbb} + 65'(alu_c0);
      alu_f = '0;
      ac    = 1'b0;
      av    = 1'b0;
      case (alu_fs[4:2])
         3'b000: alu_f = ta & tbb;
         3'b001: alu_f = ta | tbb;
         3'b010: begin
            alu_f = tsum[63:0];
            ac    = tsum[64];
            av    = (ta[63] == tbb[63]) && (tsum[63] != ta[63]);
         end
         3'b011: alu_f = ta ^ tbb;
         3'b100: alu_f = ta << tbb[5:0];
         3'b101: alu_f = ta >> tbb[5:0];
         default: alu_f = '0;
      endcase
      alu_status = {av, ac, alu_f[63], alu_f == 64'd0};
   end

   // Instruction-level reference: what the op means architecturally
   function automatic exp_t model(input logic [31:0] ins, input logic [63:0] a, input logic [63:0] b,
                                  input logic [3:0] fl);
      exp_t e;
      logic [63:0] y, r;
      logic [64:0] wide;
      int kind;
      logic legal, bc, setf, c, v, t, fn, fz, fc, fv;
      e = '0; y = b; r = '0; kind = 0; legal = 1; bc = 0; setf = 0; c = 0; v = 0; t = 0;
      case (ins[31:21])
         11'b10001011000: kind = 1;
         11'b10101011000: begin kind = 1; setf = 1; end
         11'b11001011000: kind = 2;
         11'b11101011000: begin kind = 2; setf = 1; end
         11'b10001010000: kind = 3;
         11'b11101010000: begin kind = 3; setf = 1; end
         11'b10101010000: kind = 4;
         11'b11001010000: kind = 5;
         11'b11010011011: begin kind = 6; y = {58'd0, ins[15:10]}; end
         11'b11010011010: begin kind = 7; y = {58'd0, ins[15:10]}; end
         default: begin
            y = {52'd0, ins[21:10]};
            case (ins[31:22])
               10'b1001000100: kind = 1;
               10'b1011000100: begin kind = 1; setf = 1; end
               10'b1101000100: kind = 2;
               10'b1111000100: begin kind = 2; setf = 1; end
               10'b1001001000: kind = 3;
               10'b1011001000: kind = 4;
               10'b1101001000: kind = 5;
               default: if (ins[31:24] == 8'h54) bc = 1; else legal = 0;
            endcase
         end
      endcase
      case (kind)
         1: begin wide = {1'b0, a} + {1'b0, y}; r = wide[63:0]; c = wide[64];
                  v = (a[63] == y[63]) && (r[63] != a[63]); end
         2: begin r = a - y; c = (a >= y); v = (a[63] != y[63]) && (r[63] != a[63]); end
         3: r = a & y;
         4: r = a | y;
         5: r = a ^ y;
         6: r = a << y;
         7: r = a >> y;
         default: r = '0;
      endcase
      fv = fl[3]; fc = fl[2]; fn = fl[1]; fz = fl[0];
      case (ins[3:0])
         4'd0:  t = fz;
         4'd1:  t = !fz;
         4'd2:  t = fc;
         4'd3:  t = !fc;
         4'd4:  t = fn;
         4'd5:  t = !fn;
         4'd6:  t = fv;
         4'd7:  t = !fv;
         4'd8:  t = fc && !fz;
         4'd9:  t = !(fc && !fz);
         4'd10: t = (fn == fv);
         4'd11: t = (fn != fv);
         4'd12: t = !fz && (fn == fv);
         4'd13: t = !(!fz && (fn == fv));
         default: t = 1;
      endcase
      e.fl  = setf ? {v, c, r[63], r == 64'd0} : fl;
      e.res = (legal && !bc) ? r : 64'd0;
      e.rd  = ins[4:0];
      e.wr  = legal && !bc && (ins[4:0] != 5'd31);
      e.br  = bc && t;
      e.ill = !legal;
      return e;
   endfunction

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
      tests++;
      if (got !== want) begin
         fails++;
         $display("FAIL %s: got %h want %h", nm, got, want);
      end
   endtask

   // Every cycle a result is presented, it must match the oldest outstanding op
   always @(negedge clock) begin
      if (reset_n && mon_en && out_valid) begin
         if (exp_q.size() == 0) begin
            chk("spurious_valid", 64'(out_valid), 64'd0);
         end else begin
            mon_e = exp_q[0];
            chk("result",  out_result,           mon_e.res);
            chk("rd",      64'(out_rd),          64'(mon_e.rd));
            chk("wr_en",   64'(out_wr_en),       64'(mon_e.wr));
            chk("br",      64'(out_br_taken),    64'(mon_e.br));
            chk("illegal", 64'(out_illegal),     64'(mon_e.ill));
            chk("flags",   64'(flags),           64'(mon_e.fl));
            chk("busy",    64'(in_ready),        64'd0);
            if (out_ready) void'(exp_q.pop_front());
         end
      end
   end

   task automatic push(input logic [31:0] ins, input logic [63:0] a, input logic [63:0] b);
      exp_t e;
      e = model(ins, a, b, mflags);
      exp_q.push_back(e);
      mflags = e.fl;
   endtask

   task automatic send(input logic [31:0] ins, input logic [63:0] a, input logic [63:0] b,
                       output bit ok);
      int k;
      k = 0;
      ok = 0;
      @(negedge clock);
      while (!in_ready && k < 20) begin
         @(negedge clock);
         k++;
      end
      if (!in_ready) begin
         chk("in_ready_timeout", 64'(in_ready), 64'd1);
         return;
      end
      in_instr = ins; in_a = a; in_b = b; in_valid = 1'b1;
      @(posedge clock);
      push(ins, a, b);
      #1 in_valid = 1'b0;
      ok = 1;
   endtask

   task automatic release_out();
      @(posedge clock);
      #1 out_ready = 1'b1;
      @(posedge clock);
      #1 out_ready = 1'b0;
   endtask

   task automatic run_op(input logic [31:0] ins, input logic [63:0] a, input logic [63:0] b,
                         input int hold);
      bit ok;
      int k;
      send(ins, a, b, ok);
      if (!ok) return;
      @(negedge clock);
      chk("lat_exec", 64'(out_valid), 64'd0);
      @(negedge clock);
      chk("lat_resp", 64'(out_valid), 64'd1);
      k = 0;
      while (!out_valid && k < 8) begin
         @(negedge clock);
         k++;
      end
      if (!out_valid) begin
         chk("valid_timeout", 64'(out_valid), 64'd1);
         if (exp_q.size() > 0) void'(exp_q.pop_front());
         return;
      end
      last_result = out_result; last_flags = flags;
      last_wr = out_wr_en; last_br = out_br_taken; last_ill = out_illegal;
      repeat (hold) @(negedge clock);
      release_out();
   endtask

   function automatic logic [31:0] rtype(input logic [10:0] op, input logic [5:0] sh, input logic [4:0] rd);
      return {op, 5'd2, sh, 5'd3, rd};
   endfunction

   function automatic logic [31:0] itype(input logic [9:0] op, input logic [11:0] imm, input logic [4:0] rd);
      return {op, imm, 5'd1, rd};
   endfunction

   function automatic logic [31:0] bcond(input logic [3:0] cc);
      return {8'h54, 19'd0, 1'b0, cc};
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [31:0] w;
      int sel;
      w = $urandom;
      sel = $urandom_range(0, 19);
      if (sel < 10) begin
         case ($urandom_range(0, 9))
            0: w[31:21] = 11'b10001011000;
            1: w[31:21] = 11'b10101011000;
            2: w[31:21] = 11'b11001011000;
            3: w[31:21] = 11'b11101011000;
            4: w[31:21] = 11'b10001010000;
            5: w[31:21] = 11'b11101010000;
            6: w[31:21] = 11'b10101010000;
            7: w[31:21] = 11'b11001010000;
            8: w[31:21] = 11'b11010011011;
            default: w[31:21] = 11'b11010011010;
         endcase
      end else if (sel < 15) begin
         case ($urandom_range(0, 6))
            0: w[31:22] = 10'b1001000100;
            1: w[31:22] = 10'b1011000100;
            2: w[31:22] = 10'b1101000100;
            3: w[31:22] = 10'b1111000100;
            4: w[31:22] = 10'b1001001000;
            5: w[31:22] = 10'b1011001000;
            default: w[31:22] = 10'b1101001000;
         endcase
      end else if (sel < 18) begin
         w[31:24] = 8'h54;
         w[4] = 1'b0;
      end
      return w;
   endfunction

   function automatic logic [63:0] rand_val();
      case ($urandom_range(0, 3))
         0: return {$urandom, $urandom};
         1: return 64'($urandom_range(0, 15));
         2: return {1'b1, 63'($urandom)};
         default: return {1'b0, 31'h7fffffff, $urandom};
      endcase
   endfunction

   initial begin
      exp_t pin;
      bit ok;
      logic [63:0] ra, rb;
      logic [31:0] rins;

      // Model pins against hand-computed values
      pin = model(rtype(11'b11101011000, 6'd0, 5'd1), 64'd5, 64'd7, 4'b0000);
      chk("model_subs_res", pin.res, 64'hFFFF_FFFF_FFFF_FFFE);
      chk("model_subs_fl", 64'(pin.fl), 64'(4'b0010));
      pin = model(bcond(4'hC), 64'd0, 64'd0, 4'b1001);
      chk("model_gt_br", 64'(pin.br), 64'd0);

      // Reset state
      repeat (2) @(negedge clock);
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_flags", 64'(flags), 64'd0);
      chk("rst_alu_fs", 64'(alu_fs), 64'd0);
      chk("rst_result", out_result, 64'd0);
      reset_n = 1'b1;
      mon_en = 1;

      // 1: SUBS 5-7
      run_op(rtype(11'b11101011000, 6'd0, 5'd1), 64'd5, 64'd7, 0);
      chk("t1_result", last_result, 64'hFFFF_FFFF_FFFF_FFFE);
      chk("t1_flags", 64'(last_flags), 64'(4'b0010));
      chk("t1_wr", 64'(last_wr), 64'd1);

      // 2: ADDS signed overflow
      run_op(rtype(11'b10101011000, 6'd0, 5'd2), 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1);
      chk("t2_result", last_result, 64'h8000_0000_0000_0000);
      chk("t2_flags", 64'(last_flags), 64'(4'b1010));

      // 3: SUBS equal, then EQ / NE
      run_op(rtype(11'b11101011000, 6'd0, 5'd3), 64'd3, 64'd3, 0);
      chk("t3_flags", 64'(last_flags), 64'(4'b0101));
      run_op(bcond(4'h0), 64'd99, 64'd98, 0);
      chk("t3_eq_br", 64'(last_br), 64'd1);
      chk("t3_eq_result", last_result, 64'd0);
      chk("t3_eq_wr", 64'(last_wr), 64'd0);
      run_op(bcond(4'h1), 64'd0, 64'd0, 0);
      chk("t3_ne_br", 64'(last_br), 64'd0);

      // 4: LSL by 63, ADDI max immediate
      run_op(rtype(11'b11010011011, 6'd63, 5'd4), 64'd1, 64'hDEAD, 0);
      chk("t4_lsl", last_result, 64'h8000_0000_0000_0000);
      chk("t4_lsl_flags", 64'(last_flags), 64'(4'b0101));
      run_op(itype(10'b1001000100, 12'hFFF, 5'd5), 64'd1, 64'd0, 0);
      chk("t4_addi", last_result, 64'h1000);

      // 5: downstream stall, then back-to-back accept after release
      send(rtype(11'b10001011000, 6'd0, 5'd6), 64'd10, 64'd20, ok);
      @(negedge clock);
      @(negedge clock);
      chk("t5_valid", 64'(out_valid), 64'd1);
      for (int i = 0; i < 5; i++) begin
         chk("t5_hold_ready", 64'(in_ready), 64'd0);
         chk("t5_hold_result", out_result, 64'd30);
         if (i == 2) begin
            in_instr = rtype(11'b11001010000, 6'd0, 5'd7);
            in_a = 64'hF0F0; in_b = 64'h0FF0; in_valid = 1'b1;
         end
         @(negedge clock);
      end
      @(posedge clock);
      #1 out_ready = 1'b1;
      @(posedge clock);
      #1 out_ready = 1'b0;
      @(negedge clock);
      chk("t5_b2b_ready", 64'(in_ready), 64'd1);
      @(posedge clock);
      push(in_instr, in_a, in_b);
      #1 in_valid = 1'b0;
      @(negedge clock);
      chk("t5_b2b_exec", 64'(out_valid), 64'd0);
      @(negedge clock);
      chk("t5_b2b_resp", 64'(out_valid), 64'd1);
      chk("t5_b2b_result", out_result, 64'hFF00);
      release_out();

      // 6: reset mid-op, illegal word, write to XZR
      send(rtype(11'b11101011000, 6'd0, 5'd1), 64'd5, 64'd7, ok);
      reset_n = 1'b0;
      exp_q.delete();
      mflags = '0;
      @(negedge clock);
      chk("t6_rst_valid", 64'(out_valid), 64'd0);
      chk("t6_rst_flags", 64'(flags), 64'd0);
      reset_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         chk("t6_no_valid", 64'(out_valid), 64'd0);
      end
      run_op(32'h0000_0000, 64'd1, 64'd2, 0);
      chk("t6_illegal", 64'(last_ill), 64'd1);
      chk("t6_ill_wr", 64'(last_wr), 64'd0);
      chk("t6_ill_flags", 64'(last_flags), 64'd0);
      run_op(rtype(11'b10001011000, 6'd0, 5'd31), 64'd1, 64'd2, 0);
      chk("t6_xzr_wr", 64'(last_wr), 64'd0);
      chk("t6_xzr_result", last_result, 64'd3);

      // Randomized ops against the model
      for (int n = 0; n < 200; n++) begin
         rins = rand_instr();
         ra = rand_val();
         rb = ($urandom_range(0, 4) == 0) ? ra : rand_val();
         run_op(rins, ra, rb, $urandom_range(0, 2));
      end

      repeat (3) @(negedge clock);
      chk("queue_drain", 64'(exp_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
